apb_requester: RTL and testbench
================================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max ACCESS-phase cycles before abort; legal range 2..255.
REQ-002 Parameter RD_LAG, default 1, meaning cycles after the completing ACCESS cycle before prdata is sampled; legal values 0, 1.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 pclk  in  1  sole clock; all state updates on rising edge.
REQ-005 preset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  32  target byte address.
REQ-010 cmd_wdata  in  32  write data; ignored for reads.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and aborted reads.
REQ-014 rsp_err  out  1  pslverr seen or timeout.
REQ-015 rsp_timeout  out  1  transfer aborted by timeout.
REQ-016 busy  out  1  state != IDLE.
REQ-017 paddr, pwdata  out  32 each  APB address / write data.
REQ-018 psel, penable, pwrite  out  1 each  APB control.
REQ-019 prdata  in  32; pready  in  1; pslverr  in  1  APB completer returns; pready tied 1 for completers without wait states.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, ACCESS, RDWAIT, RESP; one transfer outstanding at a time.
REQ-021 cmd_ready SHALL be 1 only in IDLE; on accept, cmd_addr/cmd_wdata/cmd_write are captured and state -> SETUP.
REQ-022 SETUP: psel=1, penable=0, paddr/pwrite = captured values, pwdata = captured wdata for writes, 0 for reads; -> ACCESS after exactly one cycle.
REQ-023 ACCESS: psel=1, penable=1; paddr/pwdata/pwrite unchanged from SETUP; stays while pready=0.
REQ-024 Wait counter SHALL clear on SETUP and increment each ACCESS cycle with pready=0; if pready=0 on the TIMEOUT-th ACCESS cycle, abort -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 ACCESS with pready=1 completes the transfer: write -> RESP with rsp_err=pslverr; read with RD_LAG=0 -> RESP with rsp_rdata=prdata of that cycle; read with RD_LAG=1 -> RDWAIT.
REQ-026 RDWAIT: psel=penable=0; prdata sampled at end of this single cycle into rsp_rdata; rsp_err = pslverr captured in the completing ACCESS cycle; -> RESP.
REQ-027 pready=1 on the TIMEOUT-th cycle SHALL count as completion, not timeout.
REQ-028 psel and penable SHALL be 0 in IDLE, RDWAIT and RESP; penable never 1 without psel.
REQ-029 paddr/pwrite SHALL hold last values outside transfers; pwdata 0 outside transfers.
REQ-030 RESP: rsp_valid=1; rsp_rdata/rsp_err/rsp_timeout stable until rsp_ready=1; -> IDLE on handshake; rsp_valid=0 next cycle.
REQ-031 Minimum write period SHALL be 4 cycles (accept, SETUP, ACCESS, RESP with rsp_ready=1); reads add RD_LAG.
REQ-032 cmd_valid asserted outside IDLE SHALL be ignored (no capture, no queue).

Reset
REQ-033 preset=1 at a clock edge SHALL force IDLE and set psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy to 0 and cmd_ready to 0 while reset is held.
REQ-034 Reset during any non-IDLE state SHALL abort the transfer with no response issued; cmd_ready=1 on the first cycle after preset deasserts.

Verification
REQ-035 Write 0x4/0xDEADBEEF, pready=1: psel=1 cycle after accept, penable=1 next cycle, rsp_valid next, rsp_err=0, rsp_timeout=0.
REQ-036 RD_LAG=1, read 0x4, completer drives prdata=0xDEADBEEF one cycle after ACCESS: rsp_rdata=0xDEADBEEF.
REQ-037 pready low for 3 ACCESS cycles then high: ACCESS lasts 4 cycles, paddr/pwdata constant, rsp_err=0.
REQ-038 TIMEOUT=16, pready stuck 0: exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 Write with pslverr=1 at completion: rsp_err=1, rsp_timeout=0; rsp_ready held 0 for 5 cycles keeps rsp_* stable.
REQ-040 preset=1 during ACCESS: psel=penable=0 next edge, no rsp_valid, cmd_ready=1 first cycle after release.

Source files
------------

// File: rtl/apb_requester_if.sv
// Command/response handshake plus APB completer wires for apb_requester.
// The master modport is the requester's view; slave is the surrounding system.
interface apb_requester_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    output paddr, pwdata, psel, penable, pwrite
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    input  paddr, pwdata, psel, penable, pwrite
  );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: turns one command into one APB transfer
// and holds the result as a response until it is consumed.
module apb_requester #(
  parameter int TIMEOUT = 16,
  parameter int RD_LAG  = 1
) (
  input logic            pclk,
  input logic            preset,
  apb_requester_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RDWAIT,
    RESP
  } state_t;

  // Index of the last permitted ACCESS cycle (counter starts at 0 in ACCESS).
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        timeout_q;
  logic [7:0]  wait_cnt;
  logic        accept;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_next = (!write_q && RD_LAG != 0) ? RDWAIT : RESP;
        end else if (wait_cnt == LAST_WAIT) begin
          state_next = RESP;
        end
      end
      RDWAIT: begin
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command capture, wait counting and response formation.
  always_ff @(posedge pclk) begin
    if (preset) begin
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      write_q   <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      wait_cnt  <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            write_q <= bus.cmd_write;
          end
        end
        SETUP: begin
          wait_cnt <= 8'h0;
        end
        ACCESS: begin
          if (bus.pready) begin
            err_q     <= bus.pslverr;
            timeout_q <= 1'b0;
            rdata_q   <= (!write_q && RD_LAG == 0) ? bus.prdata : 32'h0;
          end else if (wait_cnt == LAST_WAIT) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            rdata_q   <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RDWAIT: begin
          rdata_q <= bus.prdata;
        end
        default: begin
        end
      endcase
    end
  end

  // cmd_ready is masked by reset so nothing is accepted while it is held.
  assign bus.cmd_ready   = (state == IDLE) && !preset;
  assign bus.busy        = (state != IDLE);
  assign bus.psel        = (state == SETUP) || (state == ACCESS);
  assign bus.penable     = (state == ACCESS);
  assign bus.paddr       = addr_q;
  assign bus.pwrite      = write_q;
  assign bus.pwdata      = (bus.psel && write_q) ? wdata_q : 32'h0;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Randomized scoreboard bench for apb_requester: a planned completer drives APB
// returns, expected responses are queued at issue and checked by a monitor.
module tb_apb_requester;
  localparam int TIMEOUT = 16;
  localparam int RD_LAG  = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  apb_requester_if bus();

  apb_requester #(.TIMEOUT(TIMEOUT), .RD_LAG(RD_LAG)) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus.master)
  );

  always #5 pclk = ~pclk;

  rsp_t        exp_q[$];
  int          assert_count = 0;
  int          fail_count   = 0;

  logic        plan_write = 1'b0;
  logic [31:0] plan_addr  = 32'h0;
  logic [31:0] plan_wdata = 32'h0;
  int          plan_wait  = 0;
  logic        plan_err   = 1'b0;
  logic [31:0] plan_rdata = 32'h0;

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Completer: pready rises on access cycle plan_wait+1; prdata is valid only
  // in the cycle after completion, garbage elsewhere.
  int          acc_cnt = 0;
  int          setup_cnt = 0;
  bit          completed = 0;
  logic [31:0] prev_paddr = 32'h0;
  logic        prev_pwrite = 1'b0;

  always @(negedge pclk) begin
    if (preset) begin
      acc_cnt   = 0;
      setup_cnt = 0;
      completed = 0;
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = $urandom;
    end else if (bus.psel && !bus.penable) begin
      setup_cnt++;
      checkOutput("setup_paddr", bus.paddr, plan_addr);
      checkOutput("setup_pwrite", 32'(bus.pwrite), 32'(plan_write));
      checkOutput("setup_pwdata", bus.pwdata, plan_write ? plan_wdata : 32'h0);
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = $urandom;
    end else if (bus.psel && bus.penable) begin
      acc_cnt++;
      if (acc_cnt == 1) begin
        checkOutput("setup_cycles", 32'(setup_cnt), 32'd1);
      end
      checkOutput("access_paddr", bus.paddr, plan_addr);
      checkOutput("access_pwrite", 32'(bus.pwrite), 32'(plan_write));
      checkOutput("access_pwdata", bus.pwdata, plan_write ? plan_wdata : 32'h0);
      if (acc_cnt == plan_wait + 1) begin
        bus.pready  = 1'b1;
        bus.pslverr = plan_err;
        completed   = 1;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'($urandom);
      end
      bus.prdata = $urandom;
    end else begin
      checkOutput("idle_penable", 32'(bus.penable), 32'd0);
      checkOutput("idle_pwdata", bus.pwdata, 32'h0);
      checkOutput("idle_paddr_hold", bus.paddr, prev_paddr);
      checkOutput("idle_pwrite_hold", 32'(bus.pwrite), 32'(prev_pwrite));
      if (acc_cnt != 0) begin
        checkOutput("access_cycles", 32'(acc_cnt),
                    32'((plan_wait >= TIMEOUT) ? TIMEOUT : plan_wait + 1));
      end
      acc_cnt     = 0;
      setup_cnt   = 0;
      bus.prdata  = completed ? plan_rdata : $urandom;
      completed   = 0;
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
    end
    prev_paddr  = bus.paddr;
    prev_pwrite = bus.pwrite;
  end

  // Monitor: compares every cycle a response is presented (so a held response
  // must stay stable), stalls rsp_ready for 0..5 cycles, pops on handshake.
  int hold_n = 5;
  int held   = 0;

  always @(negedge pclk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected no response at %0t", $time);
        bus.rsp_ready = 1'b1;
      end else begin
        checkOutput("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
        checkOutput("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
        checkOutput("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_q[0].timeout));
        if (held < hold_n) begin
          bus.rsp_ready = 1'b0;
          held++;
        end else begin
          bus.rsp_ready = 1'b1;
          void'(exp_q.pop_front());
          held   = 0;
          hold_n = $urandom_range(0, 5);
        end
      end
    end else begin
      bus.rsp_ready = 1'($urandom);
    end
  end

  task automatic waitCmdReady();
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    checkOutput("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int wait_n, input logic err, input logic [31:0] rdata);
    rsp_t e;
    int   n;
    int   acc_len;
    int   rd_extra;
    waitCmdReady();
    plan_write = wr;
    plan_addr  = addr;
    plan_wdata = wdata;
    plan_wait  = wait_n;
    plan_err   = err;
    plan_rdata = rdata;
    e.timeout  = (wait_n >= TIMEOUT);
    e.err      = e.timeout || err;
    e.rdata    = (wr || e.timeout) ? 32'h0 : rdata;
    exp_q.push_back(e);
    acc_len  = e.timeout ? TIMEOUT : wait_n + 1;
    rd_extra = (!wr && !e.timeout) ? RD_LAG : 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(negedge pclk);
    checkOutput("accept_psel", 32'(bus.psel), 32'd1);
    checkOutput("accept_penable", 32'(bus.penable), 32'd0);
    n = 1;
    // Junk commands while busy must be ignored.
    while (!bus.rsp_valid && n < 400) begin
      bus.cmd_valid = 1'($urandom);
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      @(negedge pclk);
      n++;
    end
    bus.cmd_valid = 1'b0;
    checkOutput("rsp_latency", 32'(n), 32'(2 + acc_len + rd_extra));
  endtask

  task automatic applyResetMidTransfer();
    int n = 0;
    waitCmdReady();
    plan_write = 1'b1;
    plan_addr  = 32'hA5A5_0000;
    plan_wdata = 32'h1234_5678;
    plan_wait  = 1000;
    plan_err   = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = plan_addr;
    bus.cmd_wdata = plan_wdata;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    while (!(bus.psel && bus.penable) && n < 10) begin
      @(negedge pclk);
      n++;
    end
    checkOutput("reach_access", 32'(bus.penable), 32'd1);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    checkOutput("rst_psel", 32'(bus.psel), 32'd0);
    checkOutput("rst_penable", 32'(bus.penable), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_paddr", bus.paddr, 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    int r;
    int w;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = 32'h0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    checkOutput("reset_psel", 32'(bus.psel), 32'd0);
    checkOutput("reset_penable", 32'(bus.penable), 32'd0);
    checkOutput("reset_pwrite", 32'(bus.pwrite), 32'd0);
    checkOutput("reset_paddr", bus.paddr, 32'h0);
    checkOutput("reset_pwdata", bus.pwdata, 32'h0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    preset = 1'b0;
    @(negedge pclk);
    checkOutput("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] directed transfers");
    applyStimulus(1'b1, 32'h4, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h4, $urandom, 0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h100, 32'h1234_5678, 3, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h200, $urandom, 100, 1'b0, $urandom);
    applyStimulus(1'b1, 32'h204, $urandom, TIMEOUT - 1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h208, $urandom, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D);
    applyStimulus(1'b1, 32'h300, 32'h5555_AAAA, 0, 1'b1, 32'h0);
    applyStimulus(1'b0, 32'h304, $urandom, 2, 1'b1, 32'h0BAD_0BAD);

    $display("[TB] reset during ACCESS");
    applyResetMidTransfer();

    $display("[TB] random transfers");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        w = $urandom_range(0, 3);
      end else if (r < 8) begin
        w = $urandom_range(4, TIMEOUT + 2);
      end else begin
        w = $urandom_range(TIMEOUT - 1, TIMEOUT);
      end
      applyStimulus(1'($urandom), $urandom, $urandom, w,
                    1'($urandom_range(0, 3) == 0), $urandom);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge pclk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
